// File: rtl/axis_uart_frame_rx_if.sv
// Byte-wide AXI-Stream link used on both sides of the UART frame deframer.
interface axis_uart_frame_rx_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_frame_rx.sv
// UART byte-stream deframer: SYNC, LEN, payload, XOR checksum; forwards only good payloads.
// Optional inter-byte timeout is built when FRAME_TIMEOUT_EN is defined.
module axis_uart_frame_rx #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned TIMEOUT_CYCLES = 43_400
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [1:0]                  rx_error,
    axis_uart_frame_rx_if.slave         s_axis,
    axis_uart_frame_rx_if.master        m_axis,
    output logic                        frame_ok,
    output logic                        chk_err,
    output logic                        len_err,
    output logic                        timeout_err
);
    localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_LEN  = 3'd1,
        ST_PAY  = 3'd2,
        ST_CHK  = 3'd3,
        ST_SEND = 3'd4
    } state_t;

    state_t     state_r;
    logic [7:0] len_r;
    logic [7:0] wr_ptr_r;
    logic [7:0] rd_ptr_r;
    logic [7:0] csum_r;
    logic       s_tready_r;
    logic       m_tvalid_r;
    logic       m_tlast_r;
    logic [7:0] m_tdata_r;
    logic       frame_ok_r;
    logic       chk_err_r;
    logic       len_err_r;
    logic [7:0] buf_mem [MAX_LEN];

    logic       s_acc_s;
    logic       in_frame_s;
    logic       abort_s;
    logic       timeout_s;
    logic       m_hs_s;
    logic [7:0] rd_next_s;

    assign s_acc_s    = s_axis.tvalid && s_tready_r;
    assign in_frame_s = (state_r == ST_LEN) || (state_r == ST_PAY) || (state_r == ST_CHK);
    assign abort_s    = in_frame_s && (rx_error != 2'b00);
    assign m_hs_s     = m_tvalid_r && m_axis.tready;
    assign rd_next_s  = rd_ptr_r + 8'd1;

    // Payload buffer; contents need no reset because the FSM never reads stale slots.
    always_ff @(posedge aclk) begin
        if ((state_r == ST_PAY) && s_acc_s && !abort_s && !timeout_s) begin
            buf_mem[wr_ptr_r[AW-1:0]] <= s_axis.tdata;
        end
    end

    // Frame FSM with registered stream outputs and status pulses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r    <= ST_HUNT;
            len_r      <= 8'd0;
            wr_ptr_r   <= 8'd0;
            rd_ptr_r   <= 8'd0;
            csum_r     <= 8'd0;
            s_tready_r <= 1'b0;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            m_tdata_r  <= 8'd0;
            frame_ok_r <= 1'b0;
            chk_err_r  <= 1'b0;
            len_err_r  <= 1'b0;
        end else begin
            frame_ok_r <= 1'b0;
            chk_err_r  <= 1'b0;
            len_err_r  <= 1'b0;
            if (abort_s) begin
                chk_err_r <= 1'b1;
                state_r   <= ST_HUNT;
            end else if (timeout_s) begin
                state_r <= ST_HUNT;
            end else begin
                case (state_r)
                    ST_HUNT: begin
                        // tready rises here on the first cycle out of reset
                        s_tready_r <= 1'b1;
                        if (s_acc_s && (s_axis.tdata == SYNC_BYTE)) begin
                            state_r <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (s_acc_s) begin
                            len_r    <= s_axis.tdata;
                            csum_r   <= s_axis.tdata;
                            wr_ptr_r <= 8'd0;
                            if ((s_axis.tdata == 8'd0) || (s_axis.tdata > MAX_LEN_B)) begin
                                len_err_r <= 1'b1;
                                state_r   <= ST_HUNT;
                            end else begin
                                state_r <= ST_PAY;
                            end
                        end
                    end
                    ST_PAY: begin
                        if (s_acc_s) begin
                            csum_r <= csum_r ^ s_axis.tdata;
                            if (wr_ptr_r == (len_r - 8'd1)) begin
                                state_r <= ST_CHK;
                            end else begin
                                wr_ptr_r <= wr_ptr_r + 8'd1;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (s_acc_s) begin
                            if (s_axis.tdata == csum_r) begin
                                frame_ok_r <= 1'b1;
                                state_r    <= ST_SEND;
                                rd_ptr_r   <= 8'd0;
                                s_tready_r <= 1'b0;
                                m_tvalid_r <= 1'b1;
                                m_tdata_r  <= buf_mem[{AW{1'b0}}];
                                m_tlast_r  <= (len_r == 8'd1);
                            end else begin
                                chk_err_r <= 1'b1;
                                state_r   <= ST_HUNT;
                            end
                        end
                    end
                    ST_SEND: begin
                        if (m_hs_s) begin
                            if (m_tlast_r) begin
                                state_r    <= ST_HUNT;
                                m_tvalid_r <= 1'b0;
                                m_tlast_r  <= 1'b0;
                                s_tready_r <= 1'b1;
                            end else begin
                                rd_ptr_r  <= rd_next_s;
                                m_tdata_r <= buf_mem[rd_next_s[AW-1:0]];
                                m_tlast_r <= (rd_next_s == (len_r - 8'd1));
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_HUNT;
                    end
                endcase
            end
        end
    end

`ifdef FRAME_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] to_cnt_r;
    logic        timeout_err_r;

    // Fires on the idle cycle that brings the count up to TIMEOUT_CYCLES.
    assign timeout_s = in_frame_s && !s_acc_s && (to_cnt_r == TO_LAST);

    // Inter-byte idle counter, live only while a frame is being received.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            to_cnt_r      <= 32'd0;
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= timeout_s && !abort_s;
            if (!in_frame_s || s_acc_s || timeout_s || abort_s) begin
                to_cnt_r <= 32'd0;
            end else begin
                to_cnt_r <= to_cnt_r + 32'd1;
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    logic [31:0] unused_timeout_s;

    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
    assign timeout_s        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    assign s_axis.tready = s_tready_r;
    assign m_axis.tvalid = m_tvalid_r;
    assign m_axis.tdata  = m_tdata_r;
    assign m_axis.tlast  = m_tlast_r;
    assign frame_ok      = frame_ok_r;
    assign chk_err       = chk_err_r;
    assign len_err       = len_err_r;
endmodule

// File: tb/tb_axis_uart_frame_rx.sv
// Randomized frame stimulus checked against a transaction-level frame model and a per-cycle monitor.
module tb_axis_uart_frame_rx;
    localparam int MAX_LEN = 64;
`ifdef FRAME_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 20;
`else
    localparam int TIMEOUT_CYCLES = 43_400;
`endif

    logic       aclk     = 1'b0;
    logic       aresetn  = 1'b0;
    logic [1:0] rx_error = 2'b00;
    logic       frame_ok;
    logic       chk_err;
    logic       len_err;
    logic       timeout_err;

    axis_uart_frame_rx_if s_if ();
    axis_uart_frame_rx_if m_if ();

    assign s_if.tlast = 1'b0;

    axis_uart_frame_rx #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .rx_error    (rx_error),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .frame_ok    (frame_ok),
        .chk_err     (chk_err),
        .len_err     (len_err),
        .timeout_err (timeout_err)
    );

    always #5 aclk = ~aclk;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] exp_q [$];     // {tlast, tdata} of every payload byte the model expects
    int         pulse_q [$];   // 1 frame_ok, 2 chk_err, 3 len_err, 4 timeout_err
    bit         ready_forced = 1'b0;
    bit         ready_val    = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] frame_csum(input logic [7:0] pay [$]);
        logic [7:0] c;
        c = 8'(pay.size());
        foreach (pay[i]) c = c ^ pay[i];
        return c;
    endfunction

    function automatic bit len_legal(input logic [7:0] l);
        return (int'(l) >= 1) && (int'(l) <= MAX_LEN);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic gap(input int gmax);
        if (gmax > 0) tick(int'($urandom_range(0, gmax)));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        s_if.tdata  = b;
        s_if.tvalid = 1'b1;
        @(negedge aclk);
        while (!s_if.tready && (waited < 3000)) begin
            @(negedge aclk);
            waited++;
        end
        if (waited >= 3000) check("s_accept_wait", 32'(s_if.tready), 32'd1);
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] pay [$], input logic [7:0] chk_byte, input int gmax);
        if (chk_byte == frame_csum(pay)) begin
            pulse_q.push_back(1);
            foreach (pay[i]) exp_q.push_back({(i == (pay.size() - 1)), pay[i]});
        end else begin
            pulse_q.push_back(2);
        end
        send_byte(8'hA5);
        gap(gmax);
        send_byte(8'(pay.size()));
        foreach (pay[i]) begin
            gap(gmax);
            send_byte(pay[i]);
        end
        gap(gmax);
        send_byte(chk_byte);
    endtask

    task automatic send_len_only(input logic [7:0] l);
        if (!len_legal(l)) pulse_q.push_back(3);
        send_byte(8'hA5);
        send_byte(l);
    endtask

    task automatic send_abort(input int len, input int k);
        pulse_q.push_back(2);
        send_byte(8'hA5);
        send_byte(8'(len));
        for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)));
        gap(2);
        rx_error = 2'($urandom_range(1, 3));
        tick(1);
        rx_error = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_tready"}, 32'(s_if.tready), 32'd0);
        check({tag, "_m_tvalid"}, 32'(m_if.tvalid), 32'd0);
        check({tag, "_m_tdata"},  32'(m_if.tdata),  32'd0);
        check({tag, "_m_tlast"},  32'(m_if.tlast),  32'd0);
        check({tag, "_frame_ok"}, 32'(frame_ok),    32'd0);
        check({tag, "_chk_err"},  32'(chk_err),     32'd0);
        check({tag, "_len_err"},  32'(len_err),     32'd0);
        check({tag, "_timeout"},  32'(timeout_err), 32'd0);
    endtask

    // Downstream ready: random unless the directed sequence forces it.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #2;
            m_if.tready = ready_forced ? ready_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Per-cycle monitor: pulses, payload beats, backpressure stability, input ready in SEND.
    initial begin
        int         npulse;
        int         code;
        bit         hold_pending;
        logic [9:0] held;
        hold_pending = 1'b0;
        held         = 10'd0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                hold_pending = 1'b0;
            end else begin
                npulse = int'(frame_ok) + int'(chk_err) + int'(len_err) + int'(timeout_err);
                if (npulse != 0) begin
                    check("pulse_onehot", 32'(npulse), 32'd1);
                    code = frame_ok ? 1 : (chk_err ? 2 : (len_err ? 3 : 4));
                    check("pulse_expected", 32'(pulse_q.size() != 0), 32'd1);
                    if (pulse_q.size() != 0) check("pulse_kind", 32'(code), 32'(pulse_q.pop_front()));
                end
                if (m_if.tvalid) check("s_tready_in_send", 32'(s_if.tready), 32'd0);
                if (hold_pending) check("hold_stable", 32'({m_if.tvalid, m_if.tlast, m_if.tdata}), 32'(held));
                if (m_if.tvalid && m_if.tready) begin
                    check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("beat", 32'({m_if.tlast, m_if.tdata}), 32'(exp_q.pop_front()));
                end
                hold_pending = m_if.tvalid && !m_if.tready;
                held         = {m_if.tvalid, m_if.tlast, m_if.tdata};
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pay [$];
        logic [7:0] b;
        logic [7:0] cs;
        int         kind;
        int         len;

        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'd0;

        pay = {8'h11, 8'h22, 8'h33};
        check("model_csum_pin_3", 32'(frame_csum(pay)), 32'h03);
        pay = {8'hA5};
        check("model_csum_pin_1", 32'(frame_csum(pay)), 32'hA4);

        tick(3);
        check_all_zero("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        tick(1);
        check("post_reset_s_tready", 32'(s_if.tready), 32'd1);
        check("post_reset_m_tvalid", 32'(m_if.tvalid), 32'd0);

        // Good frame with exact output timing.
        ready_forced = 1'b1;
        ready_val    = 1'b1;
        pay = {8'h11, 8'h22, 8'h33};
        send_frame(pay, 8'h03, 0);
        check("good_frame_ok",   32'(frame_ok),     32'd1);
        check("good_first_vld",  32'(m_if.tvalid),  32'd1);
        check("good_first_data", 32'(m_if.tdata),   32'h11);
        check("good_first_last", 32'(m_if.tlast),   32'd0);
        check("good_s_tready",   32'(s_if.tready),  32'd0);
        tick(5);
        check("good_drained", 32'(exp_q.size()), 32'd0);

        // Bad checksum, then a good frame.
        send_frame(pay, 8'h04, 0);
        check("badchk_pulse", 32'(chk_err), 32'd1);
        check("badchk_m_tvalid", 32'(m_if.tvalid), 32'd0);
        tick(3);
        send_frame(pay, 8'h03, 1);
        tick(5);

        // Length errors, leading garbage, largest legal length.
        send_len_only(8'h00);
        check("len0_pulse", 32'(len_err), 32'd1);
        send_len_only(8'h41);
        check("len65_pulse", 32'(len_err), 32'd1);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        send_frame(pay, 8'h03, 0);
        pay.delete();
        for (int i = 0; i < MAX_LEN; i++) pay.push_back(8'($urandom_range(0, 255)));
        send_frame(pay, frame_csum(pay), 0);
        tick(MAX_LEN + 4);
        check("maxlen_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: held low, then toggling.
        pay.delete();
        for (int i = 0; i < 5; i++) pay.push_back(8'($urandom_range(0, 255)));
        ready_val = 1'b0;
        send_frame(pay, frame_csum(pay), 0);
        tick(10);
        check("bp_tvalid_held", 32'(m_if.tvalid), 32'd1);
        check("bp_tdata_held",  32'(m_if.tdata),  32'(pay[0]));
        for (int i = 0; i < 14; i++) begin
            ready_val = ~ready_val;
            tick(1);
        end
        ready_val = 1'b1;
        tick(6);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // rx_error during payload.
        send_abort(3, 1);
        check("abort_pulse", 32'(chk_err), 32'd1);
        tick(2);

        // Reset in the middle of SEND discards everything.
        ready_val = 1'b0;
        pay = {8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(pay, frame_csum(pay), 0);
        tick(2);
        aresetn = 1'b0;
        #2;
        check_all_zero("midsend_reset");
        exp_q.delete();
        pulse_q.delete();
        tick(2);
        @(negedge aclk);
        aresetn   = 1'b1;
        ready_val = 1'b1;
        tick(20);
        check("after_reset_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("after_reset_s_tready", 32'(s_if.tready), 32'd1);

`ifdef FRAME_TIMEOUT_EN
        // Stalled frame times out; the next one goes through.
        pulse_q.push_back(4);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        tick(25);
        check("timeout_seen", 32'(pulse_q.size()), 32'd0);
        pay = {8'h11, 8'h22, 8'h33};
        send_frame(pay, 8'h03, 0);
        tick(5);
`endif

        // Randomized traffic.
        ready_forced = 1'b0;
        for (int it = 0; it < 60; it++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) begin
                if ($urandom_range(0, 3) == 0) len = ($urandom_range(0, 1) == 0) ? 1 : MAX_LEN;
                else len = int'($urandom_range(1, 16));
                pay.delete();
                for (int i = 0; i < len; i++) begin
                    b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
                    pay.push_back(b);
                end
                cs = frame_csum(pay);
                if (kind == 5) cs = cs ^ 8'($urandom_range(1, 255));
                send_frame(pay, cs, 2);
            end else if (kind == 6) begin
                b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
                send_len_only(b);
            end else if (kind == 7) begin
                len = int'($urandom_range(2, 16));
                send_abort(len, int'($urandom_range(1, len)));
            end else if (kind == 8) begin
                repeat ($urandom_range(1, 4)) begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hA5) b = 8'h00;
                    send_byte(b);
                end
            end else begin
                tick(int'($urandom_range(0, 5)));
            end
            if ($urandom_range(0, 2) == 0) begin
                rx_error = 2'($urandom_range(1, 3));
                tick(1);
                rx_error = 2'b00;
            end
        end

        ready_forced = 1'b1;
        ready_val    = 1'b1;
        tick(200);
        check("final_beats_left",  32'(exp_q.size()),   32'd0);
        check("final_pulses_left", 32'(pulse_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_uart_frame_rx.md
Name: axis_uart_frame_rx

Overview:
- AXI-Stream frame deframer placed directly downstream of the UART transceiver receive path. Its slave port takes that block's m_axis byte stream and its rx_error flags.
- Hunts for a sync byte, reads a length, buffers the payload and checks an XOR checksum.
- Releases only good payloads on a master AXI-Stream port, with tlast marking the last byte.
- Bad frames are dropped and reported through one-cycle status pulses.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 64, largest payload length accepted; legal range 1..255. Sets the buffer depth.
- TIMEOUT_CYCLES, 43_400, inter-byte timeout in aclk cycles. Default is about 5 byte times at 115200 baud and 100 MHz. Used only with FRAME_TIMEOUT_EN.

Ports:
- aclk  input  1  clock; everything is sampled on the rising edge.
- aresetn  input  1  asynchronous active-low reset.
- rx_error  input  2  receiver error flags; any nonzero value aborts a frame in progress.
- s_axis_tdata  input  8  received byte.
- s_axis_tvalid  input  1  received byte valid.
- s_axis_tready  output  1  deframer can accept a byte.
- m_axis_tdata  output  8  payload byte.
- m_axis_tvalid  output  1  payload byte valid.
- m_axis_tready  input  1  downstream accepts the payload byte.
- m_axis_tlast  output  1  marks the final payload byte.
- frame_ok  output  1  one-cycle pulse: frame accepted.
- chk_err  output  1  one-cycle pulse: checksum mismatch or rx_error abort.
- len_err  output  1  one-cycle pulse: LEN is 0 or greater than MAX_LEN.
- timeout_err  output  1  one-cycle pulse: inter-byte timeout; tied to 0 when the macro is absent.

Behaviour:
- Reset (asynchronous, aresetn=0):
  - State goes to HUNT; length, pointer and checksum registers clear.
  - Every output is 0 except s_axis_tready, which is 1 after reset release.
  - Reset mid-frame or mid-SEND discards the buffer; no partial output follows.
- Frame format: SYNC, LEN, LEN payload bytes, CHK. CHK = LEN XOR all payload bytes.
- Accept: a byte is taken when s_axis_tvalid && s_axis_tready.
- s_axis_tready: 1 in HUNT, LEN, PAY and CHK; 0 in SEND.
- States:
  - HUNT: bytes other than SYNC_BYTE are discarded silently. SYNC_BYTE → LEN.
  - LEN: the accepted byte is stored as len, with csum = byte.
    - Byte is 0 or > MAX_LEN → len_err pulse the next cycle, back to HUNT.
    - Otherwise → PAY, wr_ptr = 0.
  - PAY: each accepted byte is written to buf[wr_ptr]; csum ^= byte; wr_ptr++.
    - The byte with wr_ptr == len-1 → CHK.
    - SYNC_BYTE in the payload is ordinary data.
  - CHK: the accepted byte is compared with csum.
    - Equal → frame_ok pulse the next cycle, SEND, rd_ptr = 0.
    - Not equal → chk_err pulse the next cycle, HUNT.
  - SEND:
    - m_axis_tvalid = 1; m_axis_tdata = buf[rd_ptr]; m_axis_tlast = (rd_ptr == len-1).
    - On handshake rd_ptr++.
    - Handshake with tlast → HUNT; s_axis_tready returns to 1 the following cycle.
- Output timing: the first payload byte is valid in the cycle after the CHK byte is accepted.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, tdata, tlast and tvalid hold stable. tvalid never drops before its handshake.
- rx_error: nonzero in any cycle in LEN, PAY or CHK → chk_err pulse the next cycle, HUNT. It is ignored in HUNT and SEND.
- Priority in the same cycle: reset > rx_error abort > timeout > byte accept.
- Widths: len and pointers are 8 bits; pointers never exceed MAX_LEN-1. csum is 8 bits and wraps naturally under XOR.
- Status pulses are mutually exclusive; at most one is asserted per cycle.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- Defined:
  - A counter clears on each accepted byte and on entry to LEN.
  - It counts every other cycle spent in LEN, PAY or CHK.
  - On reaching TIMEOUT_CYCLES: timeout_err pulses the next cycle and the state goes to HUNT.
  - The counter is inactive in HUNT and SEND.
- Not defined: no counter is built; timeout_err is constant 0; a stalled frame waits indefinitely.

Test Plan:
- Good frame: A5 03 11 22 33 03 → m_axis emits 11, 22, 33 with tlast only on 33; exactly one frame_ok; no error pulses.
- Bad checksum: A5 03 11 22 33 04 → chk_err pulse; m_axis_tvalid never asserts; next good frame passes normally.
- Length errors: A5 00, and A5 41 with MAX_LEN=64 → len_err each time, back to HUNT. Leading garbage 00 FF 12 before a good frame is ignored.
- Backpressure: good frame with m_axis_tready toggling 0/1 and held low 10 cycles → data stable, order preserved; s_axis_tready=0 throughout SEND.
- Aborts: rx_error=2'b01 pulsed during PAY → chk_err, HUNT. aresetn pulsed low mid-SEND → all outputs 0, no further payload output.
- With FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=20: A5 03 11, then 25 idle cycles → timeout_err pulse, HUNT; following good frame passes.
